bus_rr_arbit: RTL and testbench

BUS_RR_ARBIT -- requirements
Module: bus_rr_arbit

---
 rtl/bus_rr_arbit_if.sv | 25 ++
 rtl/bus_rr_arbit.sv | 118 +++++++++++
 tb/tb_bus_rr_arbit.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_rr_arbit_if.sv
// Request/grant bundle between four bus masters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) returns registered grant status.
interface bus_rr_arbit_if;
    logic [3:0] m_req;
    logic [3:0] m_grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic [3:0] burst_cnt;

    modport master (
        output m_req,
        input  m_grant,
        input  grant_id,
        input  bus_busy,
        input  burst_cnt
    );

    modport slave (
        input  m_req,
        output m_grant,
        output grant_id,
        output bus_busy,
        output burst_cnt
    );
endinterface

// File: rtl/bus_rr_arbit.sv
// Four-master round-robin bus arbiter with a per-tenure burst quota; grant is registered, one edge after request.
// No backpressure: a requester simply holds m_req until granted; owners are never pre-empted before release.
module bus_rr_arbit #(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    bus_rr_arbit_if.slave     bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LP_LAST_CNT = 4'(MAX_BURST - 1);

    state_t     r_state;
    logic [1:0] r_last_id;
    logic [3:0] r_grant;
    logic [1:0] r_grant_id;
    logic       r_busy;
    logic [3:0] r_burst;

    state_t     w_state_nxt;
    logic [1:0] w_last_id_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_grant_id_nxt;
    logic       w_busy_nxt;
    logic [3:0] w_burst_nxt;
    logic [1:0] w_pick_id;
    logic       w_any_req;
    logic       w_release;

    // Highest priority is base+1, lowest is base itself; scanning backwards lets the best match win.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] id;
        logic [1:0] idx;
        id = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (req[idx]) id = idx;
        end
        return id;
    endfunction

    // The owner always equals r_last_id while granted, so one search covers both idle and handover.
    assign w_pick_id = rr_pick(bus.m_req, r_last_id);
    assign w_any_req = |bus.m_req;
    assign w_release = !bus.m_req[r_last_id] || (r_burst == LP_LAST_CNT);

    always_comb begin
        w_state_nxt    = r_state;
        w_last_id_nxt  = r_last_id;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_burst_nxt    = r_burst;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = ST_GRANT;
                    w_last_id_nxt  = w_pick_id;
                    w_grant_nxt    = 4'b0001 << w_pick_id;
                    w_grant_id_nxt = w_pick_id;
                    w_busy_nxt     = 1'b1;
                    w_burst_nxt    = 4'd0;
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_burst_nxt = r_burst + 4'd1;
                end else if (w_any_req) begin
                    w_last_id_nxt  = w_pick_id;
                    w_grant_nxt    = 4'b0001 << w_pick_id;
                    w_grant_id_nxt = w_pick_id;
                    w_burst_nxt    = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                    w_burst_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                w_burst_nxt = 4'd0;
            end
        endcase
    end

    // last_id resets to 3 so master 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_id  <= 2'd3;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'd0;
            r_busy     <= 1'b0;
            r_burst    <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_id  <= w_last_id_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_burst    <= w_burst_nxt;
        end
    end

    assign bus.m_grant   = r_grant;
    assign bus.grant_id  = r_grant_id;
    assign bus.bus_busy  = r_busy;
    assign bus.burst_cnt = r_burst;

endmodule

// File: tb/tb_bus_rr_arbit.sv
// Directed bench for bus_rr_arbit: a vector table for short sequences plus long held-request runs.
module tb_bus_rr_arbit;

    localparam int MB = 8;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    bus_rr_arbit_if bif ();

    bus_rr_arbit #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] e_grant;
        logic [1:0] e_id;
        logic       e_busy;
        logic [3:0] e_cnt;
        logic       chk_id;
    } vec_t;

    vec_t tbl [20];

    // Drive inputs, take one edge, then compare just after it.
    task automatic apply(input string name, input logic rst, input logic [3:0] req,
                         input logic [3:0] e_grant, input logic [1:0] e_id,
                         input logic e_busy, input logic [3:0] e_cnt, input logic chk_id);
        logic ok;
        reset     = rst;
        bif.m_req = req;
        @(posedge clk);
        #1;
        n_vec++;
        ok = (bif.m_grant === e_grant) && (bif.bus_busy === e_busy) &&
             (bif.burst_cnt === e_cnt) && (!chk_id || (bif.grant_id === e_id));
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b cnt=%0d, want grant=%b id=%0d busy=%b cnt=%0d",
                     name, bif.m_grant, bif.grant_id, bif.bus_busy, bif.burst_cnt,
                     e_grant, e_id, e_busy, e_cnt);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        bif.m_req = 4'b0000;

        //          rst   req      grant    id    busy  cnt   chkid
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 4'd1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 4'd2, 1'b1};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'd0, 1'b1};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'd1, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[9]  = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 4'd0, 1'b1};
        tbl[10] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b1};
        tbl[11] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 4'd0, 1'b1};
        tbl[12] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'd1, 1'b1};
        tbl[13] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'd2, 1'b1};
        tbl[14] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'd3, 1'b1};
        tbl[15] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'd4, 1'b1};
        tbl[16] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'd5, 1'b1};
        tbl[17] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1};
        tbl[18] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].req, tbl[i].e_grant,
                  tbl[i].e_id, tbl[i].e_busy, tbl[i].e_cnt, tbl[i].chk_id);
        end

        // Masters 1 and 3 alternate full quotas, then master 1 returns.
        apply("rst_a", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 2 * MB + 1; i++) begin
            logic [1:0] id;
            id = ((i / MB) % 2 == 0) ? 2'd1 : 2'd3;
            apply($sformatf("alt13_%0d", i), 1'b0, 4'b1010, 4'b0001 << id, id,
                  1'b1, 4'(i % MB), 1'b1);
        end

        // All four requesting: full rotation with no idle cycle.
        apply("rst_b", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 4 * MB + 1; i++) begin
            logic [1:0] id;
            id = 2'((i / MB) % 4);
            apply($sformatf("rot_%0d", i), 1'b0, 4'b1111, 4'b0001 << id, id,
                  1'b1, 4'(i % MB), 1'b1);
        end

        // A lone requester is re-granted back to back across quota expiry.
        apply("rst_c", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("solo2_%0d", i), 1'b0, 4'b0100, 4'b0100, 2'd2,
                  1'b1, 4'(i % MB), 1'b1);
        end
        apply("solo2_drop", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
